// File: rtl/ecc_decode_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ecc_decode_stage : registered SECDED decoder with saturating error counters
// Revision 1.0
// ---------------------------------------------------------------------------
module ecc_decode_stage #(
  parameter  int DataWidth = 64,
  parameter  int CntWidth  = 16,
  localparam int ParWidth  = (DataWidth <= 1)   ? 2 :
                             (DataWidth <= 4)   ? 3 :
                             (DataWidth <= 11)  ? 4 :
                             (DataWidth <= 26)  ? 5 :
                             (DataWidth <= 57)  ? 6 :
                             (DataWidth <= 120) ? 7 :
                             (DataWidth <= 247) ? 8 :
                             (DataWidth <= 502) ? 9 : 10,
  localparam int CwWidth   = DataWidth + ParWidth,
  localparam int EncWidth  = CwWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [EncWidth-1:0]  in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_single_err_o,
  output logic                 out_double_err_o,
  output logic [ParWidth-1:0]  out_syndrome_o,
  input  logic                 cnt_clear_i,
  output logic [CntWidth-1:0]  single_cnt_o,
  output logic [CntWidth-1:0]  double_cnt_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [CwWidth-1:0]   cw;
  logic [CwWidth-1:0]   cw_fix;
  logic [ParWidth-1:0]  syn;
  logic                 par_all;
  logic                 is_single;
  logic                 is_double;
  logic [DataWidth-1:0] dec_data;
  logic                 in_fire;

  logic                 valid_q,  valid_d;
  logic [DataWidth-1:0] data_q,   data_d;
  logic                 single_q, single_d;
  logic                 double_q, double_d;
  logic [ParWidth-1:0]  syn_q,    syn_d;
  logic [CntWidth-1:0]  scnt_q,   scnt_d;
  logic [CntWidth-1:0]  dcnt_q,   dcnt_d;

  always_comb begin
    int j;
    cw       = in_data_i[CwWidth-1:0];
    syn      = '0;
    cw_fix   = cw;
    dec_data = '0;
    j        = 0;
    for (int k = 1; k <= CwWidth; k++) begin
      if (cw[k-1]) syn = syn ^ ParWidth'(k);
    end
    par_all   = ^in_data_i;
    // Syndromes beyond the code word length cannot come from one flipped bit.
    is_single = par_all && (int'(syn) <= CwWidth);
    is_double = ((syn != '0) && !par_all) || (par_all && (int'(syn) > CwWidth));
    for (int k = 1; k <= CwWidth; k++) begin
      if (is_single && (int'(syn) == k)) cw_fix[k-1] = ~cw[k-1];
    end
    for (int k = 1; k <= CwWidth; k++) begin
      if ((k & (k - 1)) != 0) begin
        dec_data[j] = cw_fix[k-1];
        j = j + 1;
      end
    end
  end

  assign in_ready_o = !valid_q || out_ready_i;
  assign in_fire    = in_valid_i && in_ready_o;

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    single_d = single_q;
    double_d = double_q;
    syn_d    = syn_q;
    scnt_d   = scnt_q;
    dcnt_d   = dcnt_q;
    if (in_fire) begin
      valid_d  = 1'b1;
      data_d   = dec_data;
      single_d = is_single;
      double_d = is_double;
      syn_d    = syn;
    end else if (out_ready_i) begin
      valid_d  = 1'b0;
    end
    if (cnt_clear_i) begin
      scnt_d = '0;
      dcnt_d = '0;
    end else if (in_fire) begin
      if (is_single && (scnt_q != CntMax)) scnt_d = scnt_q + 1'b1;
      if (is_double && (dcnt_q != CntMax)) dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      syn_q    <= '0;
      scnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      single_q <= single_d;
      double_q <= double_d;
      syn_q    <= syn_d;
      scnt_q   <= scnt_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign out_valid_o      = valid_q;
  assign out_data_o       = data_q;
  assign out_single_err_o = valid_q & single_q;
  assign out_double_err_o = valid_q & double_q;
  assign out_syndrome_o   = valid_q ? syn_q : '0;
  assign single_cnt_o     = scnt_q;
  assign double_cnt_o     = dcnt_q;

endmodule
`default_nettype wire
